// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions for the memory responder.
// Beat geometry and responder state encoding.
package sysbus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT,
        BURST
    } resp_state_e;

    localparam int BEATS_PER_LINE = 8;
    localparam int LINE_BYTES     = 64;
    localparam int BEAT_IDX_W     = 3;
    localparam int LINE_SHIFT     = $clog2(LINE_BYTES);

    // Word index of beat 0 of the line holding a byte address.
    function automatic logic [63:0] line_word(input logic [63:0] addr);
        return (addr >> LINE_SHIFT) << BEAT_IDX_W;
    endfunction

endpackage

// File: rtl/resp_mem_array.sv
// Backing store for the Sysbus memory responder.
// One synchronous write port, one asynchronous read port, no reset.
module resp_mem_array #(
    parameter int DW    = 64,
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [WORDS];

    // Preload writes land at the clock edge in any state, reset included.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus line-fill responder: ack, fixed latency, eight-beat burst.
// Serves as the DRAM model behind the cache.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 1024,
    parameter int READ_LATENCY   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bus_reqcyc,
    output logic                         bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0]    bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]     bus_reqtag,
    output logic                         bus_respcyc,
    input  logic                         bus_respack,
    output logic [BUS_DATA_WIDTH-1:0]    bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]     bus_resptag,
    input  logic                         init_we,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [BUS_DATA_WIDTH-1:0]    init_data
);

    localparam int AW    = $clog2(MEM_WORDS);
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT =
        BEAT_IDX_W'(BEATS_PER_LINE - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'(READ_LATENCY - 1);

    resp_state_e state_q, state_d;

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BEAT_IDX_W-1:0]    beat_q, beat_d;
    logic [AW-1:0]            base_q, base_d;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;

    logic                      reqack;
    logic                      respcyc;
    logic [AW-1:0]             rd_addr;
    logic [BUS_DATA_WIDTH-1:0] rd_data;
    logic [63:0]               req_addr;

    // Upper address bits beyond the array simply wrap.
    assign req_addr = 64'(bus_req);
    assign rd_addr  = base_q | AW'(beat_q);

    resp_mem_array #(
        .DW    (BUS_DATA_WIDTH),
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (init_we),
        .waddr_i (init_addr),
        .wdata_i (init_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // State, latency counter, beat index and latched request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            base_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            tag_q   <= tag_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        base_d  = base_q;
        tag_d   = tag_q;
        reqack  = 1'b0;
        respcyc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus_reqcyc) begin
                    base_d  = AW'(line_word(req_addr));
                    tag_d   = bus_reqtag;
                    state_d = ACK;
                end
            end
            ACK: begin
                reqack = 1'b1;
                cnt_d  = CNT_LOAD;
                beat_d = '0;
                if (READ_LATENCY == 1) begin
                    state_d = BURST;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                respcyc = 1'b1;
                if (bus_respack) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus_reqack  = reqack;
    assign bus_respcyc = respcyc;
    assign bus_resp    = respcyc ? rd_data : '0;
    assign bus_resptag = respcyc ? tag_q : '0;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder.
// Expected beats are queued at request time, popped on acked beats.
module tb_sysbus_mem_responder;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int MW = 1024;
    localparam int RL = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          bus_reqcyc;
    logic          bus_reqack;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_respcyc;
    logic          bus_respack;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          init_we;
    logic [9:0]    init_addr;
    logic [DW-1:0] init_data;

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .MEM_WORDS      (MW),
        .READ_LATENCY   (RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_reqack  (bus_reqack),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .init_we     (init_we),
        .init_addr   (init_addr),
        .init_data   (init_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t          sbq[$];
    logic [DW-1:0] mdl [MW];

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int t_ack = 0;
    int bursts = 0;
    int t_first = 0;
    int t_pop = 0;
    int beats_done = 0;
    int stall_at = 0;
    int stall_left = 0;
    logic prev_respcyc = 1'b0;
    logic s_respcyc, s_reqack;
    logic [DW-1:0] s_resp;
    logic [TW-1:0] s_tag;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One clock: sample/check at negedge, then drive after posedge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        s_respcyc = bus_respcyc;
        s_reqack  = bus_reqack;
        s_resp    = bus_resp;
        s_tag     = bus_resptag;
        if (bus_reqack) begin
            ack_cnt++;
            t_ack = cyc;
        end
        if (!bus_respack && !reset) begin
            chk("stall_respcyc", 64'(bus_respcyc), 64'd1);
        end
        if (bus_respcyc) begin
            if (!prev_respcyc) begin
                bursts++;
                t_first = cyc;
            end
            if (sbq.size() == 0) begin
                chk("unexp_beat", 64'(bus_resp), 64'hdead);
            end else begin
                chk("beat_data", bus_resp, sbq[0].d);
                chk("beat_tag", 64'(bus_resptag), 64'(sbq[0].t));
                if (bus_respack) begin
                    void'(sbq.pop_front());
                    beats_done++;
                    t_pop = cyc;
                end
            end
        end
        prev_respcyc = bus_respcyc;
        @(posedge clk);
        #1;
        if (stall_left > 0 && beats_done == stall_at) begin
            bus_respack = 1'b0;
            stall_left--;
        end else begin
            bus_respack = 1'b1;
        end
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        init_we   = 1'b1;
        init_addr = 10'(a);
        init_data = d;
        mdl[a]    = d;
        tick();
        init_we   = 1'b0;
    endtask

    task automatic push_exp(input logic [DW-1:0] addr, input logic [TW-1:0] tg);
        int base;
        exp_t e;
        base = int'(((addr >> 6) << 3) & 64'h3FF);
        for (int b = 0; b < 8; b++) begin
            e.d = mdl[(base + b) % MW];
            e.t = tg;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_ack(input int a0);
        int n = 0;
        while (ack_cnt == a0 && n < 60) begin
            tick();
            n++;
        end
        chk("ack_seen", 64'(ack_cnt != a0), 64'd1);
    endtask

    task automatic wait_burst(input int b0);
        int n = 0;
        while (bursts == b0 && n < 60) begin
            tick();
            n++;
        end
        chk("burst_seen", 64'(bursts != b0), 64'd1);
    endtask

    task automatic wait_size(input int sz);
        int n = 0;
        while (sbq.size() > sz && n < 80) begin
            tick();
            n++;
        end
        chk("drain", 64'(sbq.size()), 64'(sz));
    endtask

    task automatic run_req(input logic [DW-1:0] addr, input logic [TW-1:0] tg,
                           input int st_at, input int st_len);
        int a0, b0, ta;
        push_exp(addr, tg);
        a0 = ack_cnt;
        b0 = bursts;
        beats_done = 0;
        stall_at   = st_at;
        stall_left = st_len;
        bus_req    = addr;
        bus_reqtag = tg;
        bus_reqcyc = 1'b1;
        wait_ack(a0);
        ta = t_ack;
        bus_reqcyc = 1'b0;
        wait_burst(b0);
        chk("latency", 64'(t_first - ta), 64'(RL));
        wait_size(0);
        chk("burst_len", 64'(t_pop - t_first), 64'(7 + st_len));
        tick();
        chk("one_ack", 64'(ack_cnt - a0), 64'd1);
        chk("idle_after", 64'(s_respcyc), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running want done");
        $fatal(1);
    end

    initial begin
        int a0, a1, b0, b1, ta, tl;
        reset       = 1'b1;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b1;
        init_we     = 1'b0;
        init_addr   = '0;
        init_data   = '0;
        for (int i = 0; i < MW; i++) mdl[i] = '0;

        tick();
        tick();
        chk("rst_reqack", 64'(s_reqack), 64'd0);
        chk("rst_respcyc", 64'(s_respcyc), 64'd0);
        chk("rst_resp", s_resp, 64'd0);
        chk("rst_tag", 64'(s_tag), 64'd0);

        // Words 0..3 written while reset is held.
        for (int i = 0; i < 4; i++) preload(i, 64'h100 + 64'(i));
        reset = 1'b0;
        for (int i = 4; i < 8; i++) preload(i, 64'h100 + 64'(i));
        for (int i = 8; i < 16; i++) preload(i, 64'h200 + 64'(i));
        for (int i = 16; i < 24; i++) preload(i, 64'h300 + 64'(i));
        tick();

        run_req(64'h0, 13'h5, 0, 0);
        run_req(64'h4C, 13'h11, 0, 0);
        run_req(64'h80, 13'h2, 3, 3);

        // Second request held high through the first burst.
        push_exp(64'h0, 13'h7);
        beats_done = 0;
        a0 = ack_cnt;
        b0 = bursts;
        bus_req    = 64'h0;
        bus_reqtag = 13'h7;
        bus_reqcyc = 1'b1;
        wait_ack(a0);
        push_exp(64'h40, 13'h9);
        bus_req    = 64'h40;
        bus_reqtag = 13'h9;
        a1 = ack_cnt;
        wait_size(8);
        tl = t_pop;
        chk("b2b_no_early_ack", 64'(ack_cnt - a1), 64'd0);
        wait_ack(a1);
        ta = t_ack;
        bus_reqcyc = 1'b0;
        chk("b2b_gap", 64'(ta - tl), 64'd2);
        b1 = bursts;
        wait_burst(b1);
        chk("b2b_latency", 64'(t_first - ta), 64'(RL));
        wait_size(0);
        tick();

        // Reset while waiting for data.
        a0 = ack_cnt;
        bus_req    = 64'h0;
        bus_reqtag = 13'h3;
        bus_reqcyc = 1'b1;
        wait_ack(a0);
        bus_reqcyc = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("wait_rst_respcyc", 64'(s_respcyc), 64'd0);
        chk("wait_rst_reqack", 64'(s_reqack), 64'd0);
        for (int i = 0; i < 8; i++) tick();
        run_req(64'h40, 13'h4, 0, 0);

        // Reset while beat 5 is presented.
        push_exp(64'h0, 13'h6);
        a0 = ack_cnt;
        b0 = bursts;
        bus_req    = 64'h0;
        bus_reqtag = 13'h6;
        bus_reqcyc = 1'b1;
        wait_ack(a0);
        bus_reqcyc = 1'b0;
        wait_burst(b0);
        wait_size(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sbq.delete();
        tick();
        chk("beat_rst_respcyc", 64'(s_respcyc), 64'd0);
        chk("beat_rst_reqack", 64'(s_reqack), 64'd0);
        chk("beat_rst_resp", s_resp, 64'd0);
        for (int i = 0; i < 4; i++) tick();

        // Address above the array wraps back to word 0.
        run_req(64'h10000, 13'h1A, 0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
